// File: rtl/can_crc_sequencer.sv
// CAN frame CRC check sequencer: samples the serial bus once per bit time, removes
// stuff bits, drives an external CRC-15 datapath and compares the transmitted CRC.
module can_crc_sequencer #(
    parameter int crc_CLKS_PER_BIT = 10
) (
    input  logic        Clock_TB,
    input  logic        Reset,
    input  logic        Frame_Start,
    input  logic [6:0]  Data_Bits,
    input  logic        Bit_Entrada,
    input  logic [14:0] Crc_Value,
    output logic        Crc_Clear,
    output logic        Shift_En,
    output logic        Shift_Bit,
    output logic        Busy,
    output logic        Done,
    output logic        Crc_Error,
    output logic        Form_Error,
    output logic        Stuff_Error
);

    localparam int CNT_W = (crc_CLKS_PER_BIT > 1) ? $clog2(crc_CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(crc_CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FIELD,
        CRC_CMP,
        DELIM,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       data_bits_q, data_bits_d;
    logic [6:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       run_q, run_d;
    logic             lvl_q, lvl_d;
    logic             crc_clear_q, crc_clear_d;
    logic             shift_en_q, shift_en_d;
    logic             shift_bit_q, shift_bit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             crc_err_q, crc_err_d;
    logic             form_err_q, form_err_d;
    logic             stuff_err_q, stuff_err_d;

    logic             tick;
    logic             stuff_bit;
    logic [3:0]       crc_sel;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_bits_d = data_bits_q;
        bit_idx_d   = bit_idx_q;
        run_d       = run_q;
        lvl_d       = lvl_q;
        crc_clear_d = 1'b0;
        shift_en_d  = 1'b0;
        shift_bit_d = 1'b0;
        crc_err_d   = crc_err_q;
        form_err_d  = form_err_q;
        stuff_err_d = stuff_err_q;

        tick      = (cnt_q == TICK_CNT);
        stuff_bit = (run_q == 3'd5);
        crc_sel   = 4'd14 - bit_idx_q[3:0];

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (Frame_Start && (Data_Bits != 7'd0)) begin
                    state_d     = FIELD;
                    cnt_d       = '0;
                    data_bits_d = Data_Bits;
                    bit_idx_d   = 7'd0;
                    run_d       = 3'd0;
                    lvl_d       = 1'b0;
                    crc_clear_d = 1'b1;
                    crc_err_d   = 1'b0;
                    form_err_d  = 1'b0;
                    stuff_err_d = 1'b0;
                end
            end
            FIELD, CRC_CMP, DELIM: begin
                if (tick) begin
                    // A pending stuff bit is consumed first, even ahead of the delimiter.
                    if (stuff_bit) begin
                        run_d = 3'd1;
                        lvl_d = Bit_Entrada;
                        if (Bit_Entrada == lvl_q) begin
                            stuff_err_d = 1'b1;
                            state_d     = FINISH;
                        end
                    end else if (state_q == DELIM) begin
                        if (!Bit_Entrada) begin
                            form_err_d = 1'b1;
                        end
                        state_d = FINISH;
                    end else begin
                        run_d     = ((run_q != 3'd0) && (Bit_Entrada == lvl_q)) ?
                                    3'(run_q + 3'd1) : 3'd1;
                        lvl_d     = Bit_Entrada;
                        bit_idx_d = bit_idx_q + 7'd1;
                        if (state_q == FIELD) begin
                            shift_en_d  = 1'b1;
                            shift_bit_d = Bit_Entrada;
                            if ((bit_idx_q + 7'd1) == data_bits_q) begin
                                state_d   = CRC_CMP;
                                bit_idx_d = 7'd0;
                            end
                        end else begin
                            if (Bit_Entrada != Crc_Value[crc_sel]) begin
                                crc_err_d = 1'b1;
                            end
                            if (bit_idx_q == 7'd14) begin
                                state_d = DELIM;
                            end
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == FIELD) || (state_d == CRC_CMP) || (state_d == DELIM);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge Clock_TB) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 7'd0;
            run_q       <= 3'd0;
            crc_clear_q <= 1'b0;
            shift_en_q  <= 1'b0;
            shift_bit_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            form_err_q  <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            run_q       <= run_d;
            crc_clear_q <= crc_clear_d;
            shift_en_q  <= shift_en_d;
            shift_bit_q <= shift_bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_err_q   <= crc_err_d;
            form_err_q  <= form_err_d;
            stuff_err_q <= stuff_err_d;
        end
    end

    // Frame length and last bus level are only meaningful once a frame is accepted.
    always_ff @(posedge Clock_TB) begin
        data_bits_q <= data_bits_d;
        lvl_q       <= lvl_d;
    end

    assign Crc_Clear   = crc_clear_q;
    assign Shift_En    = shift_en_q;
    assign Shift_Bit   = shift_bit_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Crc_Error   = crc_err_q;
    assign Form_Error  = form_err_q;
    assign Stuff_Error = stuff_err_q;

endmodule

// File: tb/tb_can_crc_sequencer.sv
// Directed bench for can_crc_sequencer: hand-stuffed bit strings with expected cycle
// positions of strobes, Done and error flags (4 clocks per bit).
module tb_can_crc_sequencer;

    localparam int N = 4;

    logic        Clock_TB = 1'b0;
    logic        Reset = 1'b1;
    logic        Frame_Start = 1'b0;
    logic [6:0]  Data_Bits = 7'd0;
    logic        Bit_Entrada = 1'b1;
    logic [14:0] Crc_Value = 15'd0;
    logic        Crc_Clear, Shift_En, Shift_Bit, Busy, Done;
    logic        Crc_Error, Form_Error, Stuff_Error;

    always #5 Clock_TB = ~Clock_TB;

    can_crc_sequencer #(.crc_CLKS_PER_BIT(N)) dut (
        .Clock_TB    (Clock_TB),
        .Reset       (Reset),
        .Frame_Start (Frame_Start),
        .Data_Bits   (Data_Bits),
        .Bit_Entrada (Bit_Entrada),
        .Crc_Value   (Crc_Value),
        .Crc_Clear   (Crc_Clear),
        .Shift_En    (Shift_En),
        .Shift_Bit   (Shift_Bit),
        .Busy        (Busy),
        .Done        (Done),
        .Crc_Error   (Crc_Error),
        .Form_Error  (Form_Error),
        .Stuff_Error (Stuff_Error)
    );

    int errors = 0;
    int checks = 0;

    // Observation record for the current frame; cycle 0 is the one right after acceptance.
    int         cyc;
    int         shift_cnt;
    int         shift_cyc [8];
    logic [7:0] shift_bits;
    int         done_cnt, done_cyc, busy_cnt, clr_cnt, crc_err_cyc;
    string      frame_s;
    logic [7:0] outv;

    // Frame A: SOF, CRC=0 with three stuff bits, delimiter 1
    localparam string FRAME_A = "00000100000100000101";
    // Frame B: stuff bit position carries 0
    localparam string FRAME_B = "000000";
    // Frame C: data 011, CRC bits all 0, trailing stuff bit, delimiter 1
    localparam string FRAME_C = "0110000010000010000011";
    // Frame D: data 01, CRC 15'h5555, delimiter 0 / 1
    localparam string FRAME_D0 = "011010101010101010";
    localparam string FRAME_D1 = "011010101010101011";

    task automatic clear_mon();
        cyc         = -1;
        shift_cnt   = 0;
        shift_bits  = 8'd0;
        done_cnt    = 0;
        done_cyc    = -1;
        busy_cnt    = 0;
        clr_cnt     = 0;
        crc_err_cyc = -1;
        for (int i = 0; i < 8; i++) shift_cyc[i] = -1;
    endtask

    task automatic step();
        @(posedge Clock_TB);
        #1;
        cyc++;
        if (Shift_En) begin
            if (shift_cnt < 8) begin
                shift_cyc[shift_cnt]       = cyc;
                shift_bits[shift_cnt[2:0]] = Shift_Bit;
            end
            shift_cnt++;
        end
        if (Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (Busy) busy_cnt++;
        if (Crc_Clear) clr_cnt++;
        if (Crc_Error && crc_err_cyc < 0) crc_err_cyc = cyc;
    endtask

    task automatic start_frame(input logic [6:0] db, input logic [14:0] crc, input string s);
        frame_s     = s;
        Frame_Start = 1'b1;
        Data_Bits   = db;
        Crc_Value   = crc;
        Bit_Entrada = (s.len() > 0) ? (s[0] == 8'h31) : 1'b1;
        clear_mon();
        step();
        Frame_Start = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int inj_a, input int inj_b);
        for (int k = 0; k < n; k++) begin
            step();
            if (cyc / N < frame_s.len()) Bit_Entrada = (frame_s[cyc / N] == 8'h31);
            else Bit_Entrada = 1'b1;
            Frame_Start = (cyc == inj_a) || (cyc == inj_b);
            if (Frame_Start) Data_Bits = 7'd5;
        end
        Frame_Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Frame_Start = 1'b1; Data_Bits = 7'd3;
        step(); step();
        outv = {Crc_Clear, Shift_En, Shift_Bit, Busy, Done, Crc_Error, Form_Error, Stuff_Error};
        checks++;
        if (outv !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b want 00000000", outv); end
        Reset = 1'b0; Frame_Start = 1'b0;
        step();
        checks++;
        if (Busy !== 1'b0 || Crc_Clear !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b clr=%b want 0 0", Busy, Crc_Clear);
        end
    endtask

    task automatic test_zero_len();
        Data_Bits = 7'd0; Frame_Start = 1'b1;
        clear_mon();
        step();
        Frame_Start = 1'b0;
        step(); step(); step();
        checks++;
        if (clr_cnt != 0 || busy_cnt != 0) begin
            errors++; $display("FAIL zero_len_ignored: clr=%0d busy=%0d want 0 0", clr_cnt, busy_cnt);
        end
    endtask

    task automatic test_clean_frame();
        start_frame(7'd1, 15'h0000, FRAME_A);
        run_cycles(20 * N + 4, -1, -1);
        checks++;
        if (clr_cnt != 1) begin errors++; $display("FAIL clean_clear: got %0d want 1", clr_cnt); end
        checks++;
        if (shift_cnt != 1 || shift_bits[0] !== 1'b0 || shift_cyc[0] != N) begin
            errors++; $display("FAIL clean_shift: cnt=%0d bit=%b cyc=%0d want 1 0 %0d",
                               shift_cnt, shift_bits[0], shift_cyc[0], N);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 20 * N) begin
            errors++; $display("FAIL clean_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, 20 * N);
        end
        checks++;
        if (busy_cnt != 20 * N) begin errors++; $display("FAIL clean_busy: got %0d want %0d", busy_cnt, 20 * N); end
        checks++;
        if ({Crc_Error, Form_Error, Stuff_Error} !== 3'b000) begin
            errors++; $display("FAIL clean_flags: got %b want 000", {Crc_Error, Form_Error, Stuff_Error});
        end
    endtask

    task automatic test_stuff_error();
        start_frame(7'd1, 15'h0000, FRAME_B);
        run_cycles(6 * N + 8, -1, -1);
        checks++;
        if (Stuff_Error !== 1'b1 || Crc_Error !== 1'b0) begin
            errors++; $display("FAIL stuff_flags: stuff=%b crc=%b want 1 0", Stuff_Error, Crc_Error);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 6 * N) begin
            errors++; $display("FAIL stuff_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, 6 * N);
        end
        checks++;
        if (shift_cnt != 1 || busy_cnt != 6 * N) begin
            errors++; $display("FAIL stuff_abort: shifts=%0d busy=%0d want 1 %0d", shift_cnt, busy_cnt, 6 * N);
        end
    endtask

    task automatic test_crc_error();
        start_frame(7'd3, 15'h4000, FRAME_C);
        run_cycles(22 * N + 4, -1, -1);
        checks++;
        if (crc_err_cyc != 4 * N) begin
            errors++; $display("FAIL crc_err_time: got %0d want %0d", crc_err_cyc, 4 * N);
        end
        checks++;
        if (shift_cnt != 3 || shift_bits[2:0] !== 3'b110) begin
            errors++; $display("FAIL crc_shifts: cnt=%0d bits=%b want 3 110", shift_cnt, shift_bits[2:0]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 22 * N) begin
            errors++; $display("FAIL crc_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, 22 * N);
        end
        checks++;
        if ({Crc_Error, Form_Error, Stuff_Error} !== 3'b100) begin
            errors++; $display("FAIL crc_flags: got %b want 100", {Crc_Error, Form_Error, Stuff_Error});
        end
    endtask

    task automatic test_form_error();
        start_frame(7'd2, 15'h5555, FRAME_D0);
        run_cycles(18 * N + 4, -1, -1);
        checks++;
        if ({Crc_Error, Form_Error, Stuff_Error} !== 3'b010) begin
            errors++; $display("FAIL form_flags: got %b want 010", {Crc_Error, Form_Error, Stuff_Error});
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 18 * N) begin
            errors++; $display("FAIL form_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, 18 * N);
        end
    endtask

    task automatic test_mid_reset();
        start_frame(7'd5, 15'h0000, "01010");
        run_cycles(10, -1, -1);
        checks++;
        if (shift_cnt != 2) begin errors++; $display("FAIL midrst_pre_shifts: got %0d want 2", shift_cnt); end
        Reset = 1'b1;
        step();
        outv = {Crc_Clear, Shift_En, Shift_Bit, Busy, Done, Crc_Error, Form_Error, Stuff_Error};
        checks++;
        if (outv !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got %b want 00000000", outv); end
        Reset = 1'b0;
        frame_s = "";
        clear_mon();
        run_cycles(20, -1, -1);
        checks++;
        if (done_cnt != 0 || shift_cnt != 0 || busy_cnt != 0) begin
            errors++; $display("FAIL midrst_quiet: done=%0d shifts=%0d busy=%0d want 0 0 0",
                               done_cnt, shift_cnt, busy_cnt);
        end
        start_frame(7'd2, 15'h5555, FRAME_D1);
        checks++;
        if (Crc_Clear !== 1'b1 || Busy !== 1'b1) begin
            errors++; $display("FAIL midrst_restart: clr=%b busy=%b want 1 1", Crc_Clear, Busy);
        end
        run_cycles(18 * N + 4, -1, -1);
        checks++;
        if (done_cyc != 18 * N || busy_cnt != 18 * N ||
            {Crc_Error, Form_Error, Stuff_Error} !== 3'b000) begin
            errors++; $display("FAIL midrst_frame: done=%0d busy=%0d flags=%b want %0d %0d 000",
                               done_cyc, busy_cnt, {Crc_Error, Form_Error, Stuff_Error}, 18 * N, 18 * N);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(7'd2, 15'h5555, FRAME_D1);
        run_cycles(18 * N + 4, 20, 18 * N);
        checks++;
        if (clr_cnt != 1) begin errors++; $display("FAIL b2b_clear: got %0d want 1", clr_cnt); end
        checks++;
        if (shift_cnt != 2 || (shift_cyc[1] - shift_cyc[0]) != N) begin
            errors++; $display("FAIL b2b_spacing: cnt=%0d gap=%0d want 2 %0d",
                               shift_cnt, shift_cyc[1] - shift_cyc[0], N);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 18 * N) begin
            errors++; $display("FAIL b2b_done: cnt=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, 18 * N);
        end
        checks++;
        if (Busy !== 1'b0 || busy_cnt != 18 * N) begin
            errors++; $display("FAIL b2b_busy: busy=%b cnt=%0d want 0 %0d", Busy, busy_cnt, 18 * N);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_zero_len();
        test_clean_frame();
        test_stuff_error();
        test_crc_error();
        test_form_error();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
